spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
Parametrised SPI slave receiver that runs in the system clock domain, replacing direct sck-clocked capture of the coefficient frame.
- Synchronises sck/sdi/cs and samples mode-0 data.
- Emits each completed word as a one-cycle stream.
- Delivers a complete NUM_WORDS frame atomically with a valid/ack handshake, plus length-error and overrun reporting.
- Sits between the MCU SPI pins and the filter coefficient registers.

Parameters:
WORD_W, 8, bits per word
NUM_WORDS, 42, words per frame (frame = NUM_WORDS*WORD_W bits, 336 by default)
SYNC_STAGES, 2, synchroniser depth on sck/sdi/cs (min 2)

Ports:
clk  input  1  system clock; must be at least 4x sck frequency
reset  input  1  synchronous, active-high reset
sck  input  1  SPI clock, asynchronous, idle low (mode 0)
sdi  input  1  SPI data, MSB first, asynchronous
cs  input  1  chip select, active low, asynchronous
word_data  output  WORD_W  last completed word
word_index  output  $clog2(NUM_WORDS)  index of word_data within the frame (0 = first received)
word_valid  output  1  one-clk pulse when word_data/word_index update
frame_data  output  NUM_WORDS*WORD_W  last accepted frame; word 0 in MSBs [FRAME_W-1 -: WORD_W]
frame_valid  output  1  level; frame_data holds an unacknowledged frame
frame_ack  input  1  consumer acknowledge; clears frame_valid
frame_err  output  1  one-clk pulse on cs deassert when the received bit count != FRAME_W
overrun  output  1  sticky; a full frame completed while frame_valid=1 and no ack

Behaviour:
- Reset values:
  - All outputs are 0.
  - Shift register, bit counter and word counter are cleared.
  - armed=0.
- Arming:
  - After reset the receiver ignores sck edges until synchronised cs is observed high for one clk (armed=1).
  - This prevents capturing a partial frame when reset releases mid-transfer.
- Input conditioning and sampling:
  - sck, sdi and cs each pass through SYNC_STAGES flops; one extra sck flop gives rise detection.
  - A bit is sampled on a synchronised sck rising edge while synchronised cs=0 and armed.
  - Latency from a pin sck rise to shift: SYNC_STAGES+1 clk.
- Bit counting:
  - Shift left, sdi into LSB. Bit counter and word counter increment per sampled bit/word.
  - Bits after FRAME_W within the same cs-low window are counted for error reporting only; they do not shift or emit words. The counter saturates at FRAME_W+1.
- Word output: on the clk after a word's last bit is sampled:
  - word_data = that word, word_index = its index, word_valid = 1 for exactly one clk.
- Frame completion (same clk as the final word_valid):
  - If frame_valid=0 or frame_ack=1 in that clk: frame_data loads the full shift register and frame_valid=1.
  - Otherwise frame_data is untouched, the new frame is dropped, and overrun=1.
- Handshake and overrun rules:
  - frame_ack while frame_valid=1 clears frame_valid next clk; frame_ack while frame_valid=0 is ignored.
  - Completion and ack in the same clk: frame_valid stays 1 with new data, no overrun.
  - overrun clears only on frame_ack or reset.
- cs deassert (synchronised cs 0->1):
  - Bit and word counters clear.
  - If the bit count was 0: no action.
  - If the bit count != FRAME_W (short or long): frame_err pulses for one clk. A short frame never touches frame_data. A long frame's first FRAME_W bits have already been delivered.
- sck edge coincident with cs deassert: the cs rise wins and the bit is discarded.
- Reset asserted mid-frame: everything clears as in reset; the next frame is accepted only after cs has been seen high.

Test Plan:
- WORD_W=8, NUM_WORDS=3, clk=16x sck; send 0xA5,0x3C,0x0F in one cs window -> word_valid x3 with indices 0,1,2; then frame_valid=1 and frame_data=0xA53C0F, frame_err=0.
- Default params; send 42 bytes 0x00..0x29 -> frame_data[335:328]=0x00 and frame_data[7:0]=0x29; ack -> frame_valid=0 next clk.
- NUM_WORDS=3; send 20 bits then raise cs -> 2 word_valid pulses, frame_err pulse, frame_data unchanged, frame_valid=0.
- Two full frames 0x111111 then 0x222222 with no ack -> frame_data=0x111111, overrun=1; then ack -> overrun=0 and frame_valid=0.
- Final bit of a frame lands in the same clk as frame_ack of the previous frame -> frame_valid stays 1, new frame_data, overrun=0.
- Deassert reset while cs is low mid-frame, then complete that frame -> no word_valid or frame_valid; the next full cs window is received correctly.

Source files
------------

// File: rtl/spi_frame_rx.sv
// SPI mode-0 slave receiver running on the system clock: conditions sck/sdi/cs,
// streams completed words and hands whole frames over with a valid/ack handshake.
module spi_frame_rx_sync #(
  parameter int W      = 3,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [STAGES-1:0][W-1:0] pipe;

  always_ff @(posedge clk) begin
    if (reset) pipe <= '0;
    else       pipe <= {pipe[STAGES-2:0], d};
  end

  assign q = pipe[STAGES-1];
endmodule

module spi_frame_rx #(
  parameter int WORD_W      = 8,
  parameter int NUM_WORDS   = 42,
  parameter int SYNC_STAGES = 2,
  localparam int FRAME_W    = NUM_WORDS * WORD_W,
  localparam int IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sck,
  input  logic               sdi,
  input  logic               cs,
  output logic [WORD_W-1:0]  word_data,
  output logic [IDX_W-1:0]   word_index,
  output logic               word_valid,
  output logic [FRAME_W-1:0] frame_data,
  output logic               frame_valid,
  input  logic               frame_ack,
  output logic               frame_err,
  output logic               overrun
);
  localparam int CNT_W = $clog2(FRAME_W + 2);
  localparam int BIW_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] SAT_CNT   = CNT_W'(FRAME_W + 1);
  localparam logic [BIW_W-1:0] LAST_BIT  = BIW_W'(WORD_W - 1);

  typedef enum logic {S_WAIT_CS, S_ARMED} state_t;
  state_t state, state_n;

  logic sck_s, sdi_s, cs_s, sck_d, cs_d;
  logic [FRAME_W-1:0] shreg, shreg_nx;
  logic [CNT_W-1:0]   bit_cnt;
  logic [BIW_W-1:0]   bit_in_word;
  logic [IDX_W-1:0]   word_cnt;
  logic sample, cs_rise, shift_en, word_end, frame_end;

  spi_frame_rx_sync #(.W(3), .STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    ({sck, sdi, cs}),
    .q    ({sck_s, sdi_s, cs_s})
  );

  // Stay deaf until cs has been seen high, so a transfer already in flight at reset is skipped.
  always_ff @(posedge clk) begin
    if (reset) state <= S_WAIT_CS;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (state == S_WAIT_CS && cs_s) state_n = S_ARMED;
  end

  // A cs rise masks a coincident sck rise because sampling requires cs_s low.
  assign sample    = (state == S_ARMED) && sck_s && !sck_d && !cs_s;
  assign cs_rise   = cs_s && !cs_d;
  assign shift_en  = sample && (bit_cnt < FRAME_CNT);
  assign word_end  = shift_en && (bit_in_word == LAST_BIT);
  assign frame_end = shift_en && (bit_cnt == LAST_CNT);
  assign shreg_nx  = {shreg[FRAME_W-2:0], sdi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      sck_d       <= 1'b0;
      cs_d        <= 1'b0;
      shreg       <= '0;
      bit_cnt     <= '0;
      bit_in_word <= '0;
      word_cnt    <= '0;
      word_data   <= '0;
      word_index  <= '0;
      word_valid  <= 1'b0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      sck_d      <= sck_s;
      cs_d       <= cs_s;
      word_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (frame_ack) begin
        frame_valid <= 1'b0;
        overrun     <= 1'b0;
      end
      if (cs_rise) begin
        bit_cnt     <= '0;
        bit_in_word <= '0;
        word_cnt    <= '0;
        frame_err   <= (bit_cnt != '0) && (bit_cnt != FRAME_CNT);
      end else if (sample) begin
        // Bits past the frame only advance the counter so a long frame can be flagged.
        if (bit_cnt != SAT_CNT) bit_cnt <= bit_cnt + CNT_W'(1);
        if (shift_en) begin
          shreg       <= shreg_nx;
          bit_in_word <= word_end ? '0 : bit_in_word + BIW_W'(1);
        end
        if (word_end) begin
          word_cnt   <= word_cnt + IDX_W'(1);
          word_data  <= shreg_nx[WORD_W-1:0];
          word_index <= word_cnt;
          word_valid <= 1'b1;
        end
        if (frame_end) begin
          if (!frame_valid || frame_ack) begin
            frame_data  <= shreg_nx;
            frame_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: a 3-word instance and a default 42-word instance
// share sck/sdi; words are scoreboarded, frames and flags are checked in sequence.
module tb_spi_frame_rx;
  logic clk = 1'b0;
  logic reset, sck, sdi, cs3, cs42, ack3, ack42;

  logic [7:0]   wd3, wd42;
  logic [1:0]   wi3;
  logic [5:0]   wi42;
  logic         wv3, wv42, fv3, fv42, fe3, fe42, ov3, ov42;
  logic [23:0]  fd3;
  logic [335:0] fd42;

  typedef struct {
    logic [5:0] idx;
    logic [7:0] data;
  } exp_word_t;
  exp_word_t wq3[$], wq42[$];

  int compared = 0, mismatched = 0;
  int err3 = 0, err42 = 0;

  always #5 clk = ~clk;

  spi_frame_rx #(.WORD_W(8), .NUM_WORDS(3), .SYNC_STAGES(2)) dut3 (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs3),
    .word_data(wd3), .word_index(wi3), .word_valid(wv3),
    .frame_data(fd3), .frame_valid(fv3), .frame_ack(ack3),
    .frame_err(fe3), .overrun(ov3)
  );

  spi_frame_rx dut42 (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .cs(cs42),
    .word_data(wd42), .word_index(wi42), .word_valid(wv42),
    .frame_data(fd42), .frame_valid(fv42), .frame_ack(ack42),
    .frame_err(fe42), .overrun(ov42)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode 0 at 16 clk per sck period: data set while sck low, rising edge mid-way.
  task automatic send_bit(input logic b);
    sdi = b;
    clk_wait(8);
    sck = 1'b1;
    clk_wait(8);
    sck = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input int idx, input bit to42, input bit expect_out);
    exp_word_t e;
    e.idx  = 6'(idx);
    e.data = w;
    if (expect_out) begin
      if (to42) wq42.push_back(e);
      else      wq3.push_back(e);
    end
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame3(input logic [23:0] f);
    cs3 = 1'b0;
    clk_wait(4);
    for (int k = 0; k < 3; k++) send_word(f[23-8*k -: 8], k, 1'b0, 1'b1);
    clk_wait(4);
    cs3 = 1'b1;
    clk_wait(8);
  endtask

  task automatic pulse_ack3();
    ack3 = 1'b1;
    clk_wait(1);
    ack3 = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_word_t e;
    if (fe3)  err3++;
    if (fe42) err42++;
    if (wv3) begin
      compared++;
      assert (wq3.size() > 0) else begin
        mismatched++;
        $error("FAIL w3_unexpected: observed idx %0d data %0h expected no word", wi3, wd3);
      end
      if (wq3.size() > 0) begin
        e = wq3.pop_front();
        check("w3_idx", 64'(wi3), 64'(e.idx));
        check("w3_data", 64'(wd3), 64'(e.data));
      end
    end
    if (wv42) begin
      compared++;
      assert (wq42.size() > 0) else begin
        mismatched++;
        $error("FAIL w42_unexpected: observed idx %0d data %0h expected no word", wi42, wd42);
      end
      if (wq42.size() > 0) begin
        e = wq42.pop_front();
        check("w42_idx", 64'(wi42), 64'(e.idx));
        check("w42_data", 64'(wd42), 64'(e.data));
      end
    end
  end

  initial begin
    logic [7:0] last;
    exp_word_t e;
    reset = 1'b1; sck = 1'b0; sdi = 1'b0; cs3 = 1'b1; cs42 = 1'b1; ack3 = 1'b0; ack42 = 1'b0;
    clk_wait(4);
    check("rst_word_valid", 64'(wv3), 64'd0);
    check("rst_frame_valid", 64'(fv3), 64'd0);
    check("rst_frame_data", 64'(fd3), 64'd0);
    check("rst_overrun", 64'(ov3), 64'd0);
    check("rst_frame_err", 64'(fe3), 64'd0);
    reset = 1'b0;
    clk_wait(6);

    // Basic 3-word frame
    send_frame3(24'hA53C0F);
    check("t1_fv", 64'(fv3), 64'd1);
    check("t1_fd", 64'(fd3), 64'hA53C0F);
    check("t1_err", 64'(err3), 64'd0);
    pulse_ack3();
    check("t1_ack_fv", 64'(fv3), 64'd0);

    // Full 42-byte frame on the default instance
    cs42 = 1'b0;
    clk_wait(4);
    for (int k = 0; k < 42; k++) send_word(8'(k), k, 1'b1, 1'b1);
    clk_wait(4);
    cs42 = 1'b1;
    clk_wait(8);
    check("t2_fv", 64'(fv42), 64'd1);
    check("t2_first", 64'(fd42[335:328]), 64'h00);
    check("t2_mid", 64'(fd42[335-8*20 -: 8]), 64'h14);
    check("t2_last", 64'(fd42[7:0]), 64'h29);
    check("t2_err", 64'(err42), 64'd0);
    ack42 = 1'b1;
    clk_wait(1);
    ack42 = 1'b0;
    check("t2_ack_fv", 64'(fv42), 64'd0);

    // Short frame: 20 bits
    cs3 = 1'b0;
    clk_wait(4);
    send_word(8'h12, 0, 1'b0, 1'b1);
    send_word(8'h34, 1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    clk_wait(4);
    cs3 = 1'b1;
    clk_wait(8);
    check("t3_err", 64'(err3), 64'd1);
    check("t3_fv", 64'(fv3), 64'd0);
    check("t3_fd", 64'(fd3), 64'hA53C0F);

    // Overrun: second frame dropped
    send_frame3(24'h111111);
    send_frame3(24'h222222);
    check("t4_fd", 64'(fd3), 64'h111111);
    check("t4_fv", 64'(fv3), 64'd1);
    check("t4_ov", 64'(ov3), 64'd1);
    pulse_ack3();
    check("t4_ack_ov", 64'(ov3), 64'd0);
    check("t4_ack_fv", 64'(fv3), 64'd0);

    // Completion in the same clk as the ack of the previous frame
    send_frame3(24'h333333);
    check("t5_prev_fd", 64'(fd3), 64'h333333);
    cs3 = 1'b0;
    clk_wait(4);
    send_word(8'h44, 0, 1'b0, 1'b1);
    send_word(8'h44, 1, 1'b0, 1'b1);
    last = 8'h44;
    e.idx = 6'd2;
    e.data = last;
    wq3.push_back(e);
    for (int i = 7; i >= 1; i--) send_bit(last[i]);
    sdi = last[0];
    clk_wait(8);
    sck = 1'b1;
    clk_wait(2);      // two sync stages: the shift happens at the next edge
    ack3 = 1'b1;
    clk_wait(1);
    ack3 = 1'b0;
    clk_wait(5);
    sck = 1'b0;
    clk_wait(4);
    cs3 = 1'b1;
    clk_wait(8);
    check("t5_fv", 64'(fv3), 64'd1);
    check("t5_fd", 64'(fd3), 64'h444444);
    check("t5_ov", 64'(ov3), 64'd0);

    // Reset released mid-transfer: that frame must be ignored
    cs3 = 1'b0;
    clk_wait(4);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    reset = 1'b1;
    clk_wait(3);
    reset = 1'b0;
    for (int i = 0; i < 19; i++) send_bit(i[0]);
    clk_wait(4);
    cs3 = 1'b1;
    clk_wait(8);
    check("t6_fv", 64'(fv3), 64'd0);
    check("t6_fd", 64'(fd3), 64'd0);
    check("t6_err", 64'(err3), 64'd1);
    send_frame3(24'h5A6B7C);
    check("t6_next_fv", 64'(fv3), 64'd1);
    check("t6_next_fd", 64'(fd3), 64'h5A6B7C);
    pulse_ack3();

    // Long frame: first 24 bits delivered, then error on cs rise
    cs3 = 1'b0;
    clk_wait(4);
    send_word(8'h01, 0, 1'b0, 1'b1);
    send_word(8'h02, 1, 1'b0, 1'b1);
    send_word(8'h03, 2, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    clk_wait(4);
    cs3 = 1'b1;
    clk_wait(8);
    check("t7_err", 64'(err3), 64'd2);
    check("t7_fv", 64'(fv3), 64'd1);
    check("t7_fd", 64'(fd3), 64'h010203);

    check("q3_empty", 64'(wq3.size()), 64'd0);
    check("q42_empty", 64'(wq42.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
